wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/load_align.sv | 42 ++++
 rtl/wb_stage.sv | 107 ++++++++++
 tb/tb_wb_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core constants: write-back result selects and load-type encodings.
package cpu_pkg;

    // Write-back result select
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;
    localparam logic [1:0] WB_SEL_RSVD = 2'b11;

    // Load types
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LBU = 3'b001;
    localparam logic [2:0] LD_LH  = 3'b010;
    localparam logic [2:0] LD_LHU = 3'b011;
    localparam logic [2:0] LD_LW  = 3'b100;

    // A load is misaligned when its access does not fit its natural alignment;
    // reserved load types are reported the same way so they never write.
    function automatic logic ld_misaligned(input logic [2:0] ld_type, input logic [1:0] off);
        logic mis;
        unique case (ld_type)
            LD_LB, LD_LBU: mis = 1'b0;
            LD_LH, LD_LHU: mis = off[0];
            LD_LW:         mis = (off != 2'b00);
            default:       mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian load extraction from an aligned memory word.
module load_align
    import cpu_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  off,
    input  logic [31:0] mem_data,
    output logic [31:0] ld_data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and half-word from the read word.
    always_comb begin
        byte_sel = mem_data[7:0];
        unique case (off)
            2'd0: byte_sel = mem_data[7:0];
            2'd1: byte_sel = mem_data[15:8];
            2'd2: byte_sel = mem_data[23:16];
            2'd3: byte_sel = mem_data[31:24];
            default: byte_sel = mem_data[7:0];
        endcase
        half_sel = off[1] ? mem_data[31:16] : mem_data[15:0];
    end

    // Extend the selected field according to the load type.
    always_comb begin
        ld_data = '0;
        unique case (ld_type)
            LD_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  ld_data = {24'h0, byte_sel};
            LD_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  ld_data = {16'h0, half_sel};
            LD_LW:   ld_data = mem_data;
            default: ld_data = '0;
        endcase
        misaligned = ld_misaligned(ld_type, off);
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects the result, registers it and counts retirements.
module wb_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              m_valid,
    input  logic              m_regWr,
    input  logic [REG_AW-1:0] m_WrReg,
    input  logic [1:0]        m_wbSel,
    input  logic [2:0]        m_ldType,
    input  logic [DATA_W-1:0] m_aluRes,
    input  logic [DATA_W-1:0] m_memData,
    input  logic [DATA_W-1:0] m_pc8,
    output logic              regWr,
    output logic [REG_AW-1:0] WrReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              addr_err,
    output logic [31:0]       instret
);

    logic [DATA_W-1:0] ld_data;
    logic              ld_mis;
    logic [DATA_W-1:0] res_d;
    logic              mis_d;
    logic              wr_d;
    logic              err_d;

    // WB register
    logic              valid_q;
    logic              rep_q;     // held entry has already retired once
    logic              reg_wr_q;
    logic [REG_AW-1:0] wr_reg_q;
    logic [DATA_W-1:0] wdata_q;
    logic              addr_err_q;
    logic [31:0]       instret_q;
    logic              retire;

    load_align u_load_align (
        .ld_type    (m_ldType),
        .off        (m_aluRes[1:0]),
        .mem_data   (m_memData),
        .ld_data    (ld_data),
        .misaligned (ld_mis)
    );

    // Result select and write qualification for the incoming MEM entry.
    always_comb begin
        res_d = '0;
        unique case (m_wbSel)
            WB_SEL_ALU:  res_d = m_aluRes;
            WB_SEL_LOAD: res_d = ld_data;
            WB_SEL_LINK: res_d = m_pc8;
            default:     res_d = '0;
        endcase
        mis_d = (m_wbSel == WB_SEL_LOAD) && ld_mis;
        wr_d  = m_valid && m_regWr && (m_WrReg != '0) && !mis_d && (m_wbSel != WB_SEL_RSVD);
        err_d = m_valid && mis_d;
    end

    // An entry counts once, at the end of its first cycle in WB.
    assign retire = valid_q && !rep_q;

    // WB register: capture, hold on stall (side effects once), bubble on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rep_q      <= 1'b0;
            reg_wr_q   <= 1'b0;
            wr_reg_q   <= '0;
            wdata_q    <= '0;
            addr_err_q <= 1'b0;
            instret_q  <= '0;
        end else begin
            instret_q <= instret_q + {31'h0, retire};
            if (flush) begin
                valid_q    <= 1'b0;
                rep_q      <= 1'b0;
                reg_wr_q   <= 1'b0;
                addr_err_q <= 1'b0;
            end else if (stall) begin
                rep_q      <= valid_q;
                reg_wr_q   <= 1'b0;
                addr_err_q <= 1'b0;
            end else begin
                valid_q    <= m_valid;
                rep_q      <= 1'b0;
                reg_wr_q   <= wr_d;
                wr_reg_q   <= m_WrReg;
                wdata_q    <= res_d;
                addr_err_q <= err_d;
            end
        end
    end

    assign regWr     = reg_wr_q;
    assign WrReg     = wr_reg_q;
    assign WriteData = wdata_q;
    assign addr_err  = addr_err_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: vector table with scoreboard plus corner sequences.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        m_valid;
    logic        m_regWr;
    logic [4:0]  m_WrReg;
    logic [1:0]  m_wbSel;
    logic [2:0]  m_ldType;
    logic [31:0] m_aluRes;
    logic [31:0] m_memData;
    logic [31:0] m_pc8;
    logic        regWr;
    logic [4:0]  WrReg;
    logic [31:0] WriteData;
    logic        addr_err;
    logic [31:0] instret;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        valid;
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  lt;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc8;
        logic        e_wr;
        logic [31:0] e_data;
        logic        chk_data;
        logic        e_err;
    } vec_t;

    vec_t        vecs[$];
    vec_t        sb[$];
    logic [31:0] exp_instret;
    logic [31:0] pend;

    wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .m_valid   (m_valid),
        .m_regWr   (m_regWr),
        .m_WrReg   (m_WrReg),
        .m_wbSel   (m_wbSel),
        .m_ldType  (m_ldType),
        .m_aluRes  (m_aluRes),
        .m_memData (m_memData),
        .m_pc8     (m_pc8),
        .regWr     (regWr),
        .WrReg     (WrReg),
        .WriteData (WriteData),
        .addr_err  (addr_err),
        .instret   (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic valid, input logic rw, input logic [4:0] rd,
                                input logic [1:0] sel, input logic [2:0] lt,
                                input logic [31:0] alu, input logic [31:0] mem,
                                input logic [31:0] pc8, input logic e_wr,
                                input logic [31:0] e_data, input logic chk_data,
                                input logic e_err);
        vec_t v;
        v.valid = valid; v.rw = rw; v.rd = rd; v.sel = sel; v.lt = lt;
        v.alu = alu; v.mem = mem; v.pc8 = pc8;
        v.e_wr = e_wr; v.e_data = e_data; v.chk_data = chk_data; v.e_err = e_err;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        m_valid   = v.valid;
        m_regWr   = v.rw;
        m_WrReg   = v.rd;
        m_wbSel   = v.sel;
        m_ldType  = v.lt;
        m_aluRes  = v.alu;
        m_memData = v.mem;
        m_pc8     = v.pc8;
    endtask

    // One clock with no valid MEM entry; advances the retirement model.
    task automatic idle_step();
        m_valid = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        @(posedge clk);
        #1;
        exp_instret = exp_instret + pend;
        pend = 0;
    endtask

    initial begin
        vec_t v;
        vec_t e;
        logic [31:0] i0;

        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        m_valid = 1'b0; m_regWr = 1'b0; m_WrReg = '0; m_wbSel = '0; m_ldType = '0;
        m_aluRes = '0; m_memData = '0; m_pc8 = '0;
        exp_instret = 0;
        pend = 0;

        #2;
        chk("reset_regWr", {31'h0, regWr}, 32'h0);
        chk("reset_WrReg", {27'h0, WrReg}, 32'h0);
        chk("reset_WriteData", WriteData, 32'h0);
        chk("reset_addr_err", {31'h0, addr_err}, 32'h0);
        chk("reset_instret", instret, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // valid rw rd sel lt alu mem pc8 | wr data chk err
        vecs.push_back(mk(1, 1, 5'd5, 2'b01, 3'b000, 32'h3, 32'h80FF_1234, 0, 1, 32'hFFFF_FF80, 1, 0));
        vecs.push_back(mk(1, 1, 5'd5, 2'b01, 3'b001, 32'h3, 32'h80FF_1234, 0, 1, 32'h0000_0080, 1, 0));
        vecs.push_back(mk(1, 1, 5'd6, 2'b01, 3'b010, 32'h2, 32'h7FFE_0000, 0, 1, 32'h0000_7FFE, 1, 0));
        vecs.push_back(mk(1, 1, 5'd6, 2'b01, 3'b010, 32'h1, 32'h7FFE_0000, 0, 0, 32'h0, 0, 1));
        vecs.push_back(mk(1, 1, 5'd0, 2'b00, 3'b000, 32'hDEAD_BEEF, 0, 0, 0, 32'hDEAD_BEEF, 1, 0));
        vecs.push_back(mk(1, 1, 5'd31, 2'b10, 3'b000, 32'h10, 0, 32'h0040_0008, 1, 32'h0040_0008, 1, 0));
        vecs.push_back(mk(1, 1, 5'd3, 2'b11, 3'b000, 32'h5555, 0, 32'h7777, 0, 32'h0, 1, 0));
        vecs.push_back(mk(1, 1, 5'd8, 2'b01, 3'b100, 32'h100, 32'h1234_5678, 0, 1, 32'h1234_5678, 1, 0));
        vecs.push_back(mk(1, 1, 5'd8, 2'b01, 3'b100, 32'h102, 32'h1234_5678, 0, 0, 32'h0, 0, 1));
        vecs.push_back(mk(1, 1, 5'd9, 2'b01, 3'b011, 32'h2, 32'h8001_0000, 0, 1, 32'h0000_8001, 1, 0));
        vecs.push_back(mk(1, 1, 5'd9, 2'b01, 3'b010, 32'h2, 32'h8001_0000, 0, 1, 32'hFFFF_8001, 1, 0));
        vecs.push_back(mk(1, 1, 5'd10, 2'b01, 3'b000, 32'h0, 32'h0000_007F, 0, 1, 32'h0000_007F, 1, 0));
        vecs.push_back(mk(1, 1, 5'd10, 2'b01, 3'b001, 32'h1, 32'h0000_AB00, 0, 1, 32'h0000_00AB, 1, 0));
        vecs.push_back(mk(1, 1, 5'd11, 2'b01, 3'b101, 32'h0, 32'h1111_1111, 0, 0, 32'h0, 0, 1));
        vecs.push_back(mk(0, 1, 5'd7, 2'b00, 3'b000, 32'hCAFE_0001, 0, 0, 0, 32'hCAFE_0001, 1, 0));
        vecs.push_back(mk(1, 0, 5'd7, 2'b00, 3'b000, 32'hCAFE_0002, 0, 0, 0, 32'hCAFE_0002, 1, 0));
        vecs.push_back(mk(0, 1, 5'd6, 2'b01, 3'b010, 32'h1, 32'h0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(mk(1, 1, 5'd12, 2'b00, 3'b000, 32'h0000_0001, 0, 0, 1, 32'h0000_0001, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v);
            sb.push_back(v);
            @(posedge clk);
            #1;
            exp_instret = exp_instret + pend;
            pend = {31'h0, v.valid};
            e = sb.pop_front();
            chk($sformatf("vec%0d_regWr", i), {31'h0, regWr}, {31'h0, e.e_wr});
            chk($sformatf("vec%0d_WrReg", i), {27'h0, WrReg}, {27'h0, e.rd});
            if (e.chk_data) chk($sformatf("vec%0d_WriteData", i), WriteData, e.e_data);
            chk($sformatf("vec%0d_addr_err", i), {31'h0, addr_err}, {31'h0, e.e_err});
            chk($sformatf("vec%0d_instret", i), instret, exp_instret);
        end
        idle_step();
        chk("drain_instret", instret, exp_instret);
        chk("drain_regWr", {31'h0, regWr}, 32'h0);

        // Link write held by a 3-cycle stall: one write, stable data, one retirement.
        i0 = exp_instret;
        drive(mk(1, 1, 5'd9, 2'b10, 3'b000, 32'h0, 32'h0, 32'h0040_0008, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("stall_first_regWr", {31'h0, regWr}, 32'h1);
        chk("stall_first_data", WriteData, 32'h0040_0008);
        m_valid = 1'b0;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_regWr", k), {31'h0, regWr}, 32'h0);
            chk($sformatf("stall%0d_data", k), WriteData, 32'h0040_0008);
            chk($sformatf("stall%0d_WrReg", k), {27'h0, WrReg}, 32'd9);
            chk($sformatf("stall%0d_instret", k), instret, i0 + 32'd1);
        end
        idle_step();
        chk("stall_release_regWr", {31'h0, regWr}, 32'h0);
        chk("stall_release_instret", instret, i0 + 32'd1);
        exp_instret = i0 + 32'd1;
        pend = 0;

        // Stall and flush together: bubble captured, nothing retires.
        idle_step();
        i0 = exp_instret;
        drive(mk(1, 1, 5'd4, 2'b00, 3'b000, 32'h4444_4444, 0, 0, 0, 0, 0, 0));
        stall = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_regWr", {31'h0, regWr}, 32'h0);
        chk("flush_addr_err", {31'h0, addr_err}, 32'h0);
        idle_step();
        chk("flush_instret", instret, i0);
        chk("flush_after_regWr", {31'h0, regWr}, 32'h0);

        // Asynchronous reset mid-cycle with a valid entry in WB.
        drive(mk(1, 1, 5'd6, 2'b00, 3'b000, 32'h1111_2222, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("prerst_regWr", {31'h0, regWr}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_regWr", {31'h0, regWr}, 32'h0);
        chk("arst_WrReg", {27'h0, WrReg}, 32'h0);
        chk("arst_WriteData", WriteData, 32'h0);
        chk("arst_instret", instret, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_instret = 0;
        pend = 0;
        drive(mk(1, 1, 5'd13, 2'b00, 3'b000, 32'hABCD_0013, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("postrst_regWr", {31'h0, regWr}, 32'h1);
        chk("postrst_data", WriteData, 32'hABCD_0013);
        chk("postrst_instret", instret, 32'h0);
        pend = 1;
        idle_step();
        chk("postrst_instret_inc", instret, exp_instret);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
